// File: rtl/i2c_target_if.sv
// i2c_target_if: bus pins and user byte interface of the I2C target
interface i2c_target_if;
    logic       scl;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic       addr_hit;
    modport slave (
        input  scl, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, busy, addr_hit
    );
    modport master (
        output scl, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, busy, addr_hit
    );
endinterface

// File: rtl/i2c_target.sv
// i2c_target: 7-bit address I2C responder with write capture and read byte serving
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    i2c_target_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE} state_t;
    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_q, sda_q, scl_s, sda_s, rise, fall, start, stop;
    logic [7:0] shift, shift_n, rx_data, rx_data_n, rd_byte;
    logic [3:0] cnt, cnt_n;
    logic rw, rw_n, sda_oe, sda_oe_n, wr_done, wr_done_n, rx_valid, tx_req, tx_req_n;
    logic busy, busy_n, addr_hit, addr_hit_n;
    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];
    assign rise  = scl_s & ~scl_q;
    assign fall  = ~scl_s & scl_q;
    assign start = scl_s & scl_q & sda_q & ~sda_s;
    assign stop  = scl_s & scl_q & ~sda_q & sda_s;
    // The first bit of a read byte comes from tx_data; later bits from the shifter
    assign rd_byte = (state == ADDR_ACK || cnt == 4'd0) ? bus.tx_data : shift;
    // Synchronize the asynchronous bus pins and keep one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // Next-state decode: bus conditions take priority over bit-level progress
    always_comb begin
        state_nxt = state;
        if (start)     state_nxt = ADDR;
        else if (stop) state_nxt = IDLE;
        else case (state)
            ADDR:     if (rise && cnt == 4'd7) state_nxt = (shift[6:0] == TARGET_ADDR) ? ADDR_ACK : IGNORE;
            ADDR_ACK: if (fall && sda_oe) state_nxt = rw ? RD_DATA : WR_DATA;
            WR_DATA:  if (rise && cnt == 4'd7) state_nxt = WR_ACK;
            WR_ACK:   if (fall && sda_oe) state_nxt = WR_DATA;
            RD_DATA:  if (fall && cnt == 4'd8) state_nxt = RD_ACK;
            RD_ACK:   if (rise) state_nxt = sda_s ? IGNORE : RD_DATA;
            default:  state_nxt = state;
        endcase
    end
    // Output and datapath decode; sda_oe itself marks which half of an ACK bit we are in
    always_comb begin
        shift_n    = shift;
        cnt_n      = cnt;
        rw_n       = rw;
        sda_oe_n   = sda_oe;
        rx_data_n  = rx_data;
        wr_done_n  = 1'b0;
        tx_req_n   = 1'b0;
        busy_n     = busy;
        addr_hit_n = addr_hit;
        if (start) begin
            cnt_n      = 4'd0;
            sda_oe_n   = 1'b0;
            addr_hit_n = 1'b0;
            busy_n     = 1'b1;
        end else if (stop) begin
            cnt_n      = 4'd0;
            sda_oe_n   = 1'b0;
            addr_hit_n = 1'b0;
            busy_n     = 1'b0;
        end else case (state)
            ADDR: if (rise) begin
                shift_n = {shift[6:0], sda_s};
                cnt_n   = (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
                if (cnt == 4'd7) begin
                    rw_n       = sda_s;
                    addr_hit_n = (shift[6:0] == TARGET_ADDR);
                end
            end
            ADDR_ACK: begin
                tx_req_n = rise & sda_oe & rw;
                if (fall) begin
                    sda_oe_n = sda_oe ? (rw & ~rd_byte[7]) : 1'b1;
                    shift_n  = (sda_oe && rw) ? {rd_byte[6:0], 1'b0} : shift;
                    cnt_n    = (sda_oe && rw) ? 4'd1 : 4'd0;
                end
            end
            WR_DATA: if (rise) begin
                shift_n   = {shift[6:0], sda_s};
                cnt_n     = (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
                wr_done_n = (cnt == 4'd7);
                rx_data_n = (cnt == 4'd7) ? {shift[6:0], sda_s} : rx_data;
            end
            WR_ACK: if (fall) sda_oe_n = ~sda_oe;
            RD_DATA: if (fall) begin
                sda_oe_n = (cnt == 4'd8) ? 1'b0 : ~rd_byte[7];
                shift_n  = {rd_byte[6:0], 1'b0};
                cnt_n    = (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
            end
            RD_ACK: if (rise) begin
                tx_req_n = ~sda_s;
                cnt_n    = 4'd0;
            end
            IGNORE: sda_oe_n = 1'b0;
            default: sda_oe_n = 1'b0;
        endcase
    end
    // Datapath and output registers; rx_valid trails the rx_data update by one clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift    <= '0;
            cnt      <= '0;
            rw       <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= '0;
            wr_done  <= 1'b0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
            addr_hit <= 1'b0;
        end else begin
            shift    <= shift_n;
            cnt      <= cnt_n;
            rw       <= rw_n;
            sda_oe   <= sda_oe_n;
            rx_data  <= rx_data_n;
            wr_done  <= wr_done_n;
            rx_valid <= wr_done;
            tx_req   <= tx_req_n;
            busy     <= busy_n;
            addr_hit <= addr_hit_n;
        end
    end
    assign bus.sda_oe   = sda_oe;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.tx_req   = tx_req;
    assign bus.busy     = busy;
    assign bus.addr_hit = addr_hit;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed I2C controller model driving the target over an open-drain bus
module tb_i2c_target;
    localparam int Q = 50;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sda_ctl = 1'b1;
    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int oe_cnt = 0;
    int both_cnt = 0;
    logic [7:0] rx_hist[$];
    i2c_target_if bus();
    i2c_target dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign bus.sda_in = sda_ctl & ~bus.sda_oe;
    always #5 clk = ~clk;
    // Event counters for pulses and SDA drive
    always @(posedge clk) begin
        if (bus.rx_valid) rx_hist.push_back(bus.rx_data);
        rx_cnt   <= rx_cnt + int'(bus.rx_valid);
        tx_cnt   <= tx_cnt + int'(bus.tx_req);
        oe_cnt   <= oe_cnt + int'(bus.sda_oe);
        both_cnt <= both_cnt + int'(bus.rx_valid & bus.tx_req);
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic i2c_start();
        sda_ctl = 1'b1; #(Q);
        bus.scl = 1'b1; #(Q);
        sda_ctl = 1'b0; #(Q);
        bus.scl = 1'b0; #(Q);
    endtask
    task automatic i2c_stop();
        sda_ctl = 1'b0; #(Q);
        bus.scl = 1'b1; #(Q);
        sda_ctl = 1'b1; #(Q);
    endtask
    task automatic bit_xfer(input logic b, output logic r);
        sda_ctl = b;    #(Q);
        bus.scl = 1'b1; #(Q);
        r = bus.sda_in; #(Q);
        bus.scl = 1'b0; #(Q);
    endtask
    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask
    task automatic read_byte(output logic [7:0] d, input logic ack, input logic [7:0] next_tx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bus.tx_data = next_tx;
        bit_xfer(~ack, r);
    endtask
    initial begin
        logic ack;
        logic [7:0] d;
        int b_rx, b_tx, b_oe, b_h;
        bus.scl = 1'b1;
        bus.tx_data = 8'h00;
        #(Q);
        chk("rst_sda_oe", bus.sda_oe, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_tx_req", bus.tx_req, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_addr_hit", bus.addr_hit, 0);
        #(Q);
        rst_n = 1'b1;
        #(2*Q);
        // 1: write two bytes
        b_h = rx_hist.size();
        i2c_start();
        chk("w_busy", bus.busy, 1);
        write_byte(8'h84, ack); chk("w_addr_ack", ack, 1);
        chk("w_addr_hit", bus.addr_hit, 1);
        write_byte(8'hA5, ack); chk("w_ack1", ack, 1);
        write_byte(8'h3C, ack); chk("w_ack2", ack, 1);
        i2c_stop(); #(Q);
        chk("w_busy_end", bus.busy, 0);
        chk("w_hit_end", bus.addr_hit, 0);
        chk("w_rx_count", rx_hist.size() - b_h, 2);
        chk("w_rx0", rx_hist[b_h], 8'hA5);
        chk("w_rx1", rx_hist[b_h+1], 8'h3C);
        chk("w_rx_data", bus.rx_data, 8'h3C);
        // 2: address mismatch
        b_rx = rx_cnt; b_oe = oe_cnt;
        i2c_start();
        write_byte(8'h86, ack); chk("m_addr_nack", ack, 0);
        chk("m_addr_hit", bus.addr_hit, 0);
        write_byte(8'hFF, ack); chk("m_data_nack", ack, 0);
        i2c_stop(); #(Q);
        chk("m_oe_never", oe_cnt - b_oe, 0);
        chk("m_no_rx", rx_cnt - b_rx, 0);
        // 3: read two bytes, ACK then NACK
        b_tx = tx_cnt;
        bus.tx_data = 8'h96;
        i2c_start();
        write_byte(8'h85, ack); chk("r_addr_ack", ack, 1);
        chk("r_req1", tx_cnt - b_tx, 1);
        read_byte(d, 1'b1, 8'h5A); chk("r_byte1", d, 8'h96);
        chk("r_req2", tx_cnt - b_tx, 2);
        read_byte(d, 1'b0, 8'h00); chk("r_byte2", d, 8'h5A);
        chk("r_req_total", tx_cnt - b_tx, 2);
        chk("r_oe_after_nack", bus.sda_oe, 0);
        i2c_stop(); #(Q);
        chk("r_oe_stop", bus.sda_oe, 0);
        chk("r_busy_stop", bus.busy, 0);
        // 4: write then repeated start into a read
        b_rx = rx_cnt; b_tx = tx_cnt;
        i2c_start();
        write_byte(8'h84, ack); chk("s_addr_ack", ack, 1);
        write_byte(8'h11, ack); chk("s_data_ack", ack, 1);
        bus.tx_data = 8'hC3;
        i2c_start();
        chk("s_hit_cleared", bus.addr_hit, 0);
        write_byte(8'h85, ack); chk("s_raddr_ack", ack, 1);
        chk("s_rx_data", bus.rx_data, 8'h11);
        chk("s_rx_count", rx_cnt - b_rx, 1);
        read_byte(d, 1'b0, 8'h00); chk("s_rd_byte", d, 8'hC3);
        chk("s_req_once", tx_cnt - b_tx, 1);
        i2c_stop(); #(Q);
        // 5: abort a write after 4 data bits
        b_rx = rx_cnt;
        i2c_start();
        write_byte(8'h84, ack); chk("a_addr_ack", ack, 1);
        bit_xfer(1'b1, ack); bit_xfer(1'b0, ack); bit_xfer(1'b1, ack); bit_xfer(1'b0, ack);
        i2c_stop(); #(Q);
        chk("a_no_rx", rx_cnt - b_rx, 0);
        chk("a_busy", bus.busy, 0);
        i2c_start();
        write_byte(8'h84, ack); chk("a2_addr_ack", ack, 1);
        write_byte(8'h77, ack); chk("a2_data_ack", ack, 1);
        i2c_stop(); #(Q);
        chk("a2_rx_data", bus.rx_data, 8'h77);
        // 6: reset in the middle of a read while driving SDA low
        bus.tx_data = 8'h00;
        i2c_start();
        write_byte(8'h85, ack); chk("x_addr_ack", ack, 1);
        chk("x_oe_driving", bus.sda_oe, 1);
        rst_n = 1'b0; #1;
        chk("x_oe_async", bus.sda_oe, 0);
        chk("x_busy", bus.busy, 0);
        chk("x_hit", bus.addr_hit, 0);
        chk("x_rx_data", bus.rx_data, 0);
        chk("x_tx_req", bus.tx_req, 0);
        #9;
        sda_ctl = 1'b1; bus.scl = 1'b1; #(Q);
        rst_n = 1'b1; #(Q);
        i2c_start();
        write_byte(8'h84, ack); chk("x2_addr_ack", ack, 1);
        write_byte(8'h5E, ack); chk("x2_data_ack", ack, 1);
        i2c_stop(); #(Q);
        chk("x2_rx_data", bus.rx_data, 8'h5E);
        chk("never_both_pulses", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
